// File: rtl/branch_resolve_unit_if.sv
// Bundle of decode-side prediction, memory-side resolution and result signals.
// With BRU_STATS_EN defined the bundle also carries the branch/miss counters.
interface branch_resolve_unit_if;
  logic        stall;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic        dec_pred_taken;
  logic [31:0] dec_target;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_taken;
  logic [31:0] mem_target;
  logic [1:0]  pred_result;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        full;
  logic        empty;
  logic        error;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_misses;

  modport master (
    output stall, dec_valid, dec_pc, dec_pred_taken, dec_target,
    output mem_valid, mem_pc, mem_taken, mem_target,
    input  pred_result, flush, redirect_pc, full, empty, error,
    input  stat_branches, stat_misses
  );
  modport slave (
    input  stall, dec_valid, dec_pc, dec_pred_taken, dec_target,
    input  mem_valid, mem_pc, mem_taken, mem_target,
    output pred_result, flush, redirect_pc, full, empty, error,
    output stat_branches, stat_misses
  );
`else
  modport master (
    output stall, dec_valid, dec_pc, dec_pred_taken, dec_target,
    output mem_valid, mem_pc, mem_taken, mem_target,
    input  pred_result, flush, redirect_pc, full, empty, error
  );
  modport slave (
    input  stall, dec_valid, dec_pc, dec_pred_taken, dec_target,
    input  mem_valid, mem_pc, mem_taken, mem_target,
    output pred_result, flush, redirect_pc, full, empty, error
  );
`endif
endinterface

// File: rtl/branch_resolve_unit.sv
// Memory-stage branch resolver: in-order queue of decode predictions graded at resolve.
// Optional BRU_STATS_EN adds stat_branches / stat_misses counters.
module branch_resolve_unit #(
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  branch_resolve_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] RES_NONE     = 2'b00;
  localparam logic [1:0] RES_CORRECT  = 2'b01;
  localparam logic [1:0] RES_MISS_TK  = 2'b10;
  localparam logic [1:0] RES_MISS_NTK = 2'b11;

  logic [31:0]   pc_mem     [DEPTH];
  logic          taken_mem  [DEPTH];
  logic [31:0]   target_mem [DEPTH];

  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          full_reg, empty_reg, error_reg;
  logic [1:0]    result_reg;
  logic          flush_reg;
  logic [31:0]   redirect_reg;

  logic          push_req, pop_req, push, pop, overflow, underflow;
  logic          pc_bad, outcome_ok, mispredict;
  logic [1:0]    grade;
  logic [31:0]   head_pc, head_target, fix_pc;
  logic          head_taken;

  assign head_pc     = pc_mem[rd_ptr_reg];
  assign head_taken  = taken_mem[rd_ptr_reg];
  assign head_target = target_mem[rd_ptr_reg];

  always_comb begin
    push_req   = bus.dec_valid & ~bus.stall;
    pop_req    = bus.mem_valid & ~bus.stall;
    pop        = pop_req & ~empty_reg;
    underflow  = pop_req & empty_reg;
    pc_bad     = head_pc != bus.mem_pc;
    outcome_ok = bus.mem_taken ? (head_taken && head_target == bus.mem_target) : ~head_taken;
    // A PC mismatch never grades CORRECT; direction then picks the miss flavour.
    if (!pc_bad && outcome_ok) grade = RES_CORRECT;
    else if (bus.mem_taken)    grade = RES_MISS_TK;
    else                       grade = RES_MISS_NTK;
    mispredict = pop & (grade != RES_CORRECT);
    push       = push_req & ~full_reg & ~mispredict;
    overflow   = push_req & full_reg & ~mispredict;
    fix_pc     = bus.mem_taken ? bus.mem_target : bus.mem_pc + 32'd4;
    if (mispredict)
      count_next = '0;
    else
      count_next = count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]     <= bus.dec_pc;
      taken_mem[wr_ptr_reg]  <= bus.dec_pred_taken;
      target_mem[wr_ptr_reg] <= bus.dec_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      error_reg    <= 1'b0;
      result_reg   <= RES_NONE;
      flush_reg    <= 1'b0;
      redirect_reg <= '0;
    end else begin
      // Every younger entry is wrong-path after a miss, so the queue restarts at slot 0.
      if (mispredict) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
      end else begin
        rd_ptr_reg <= rd_ptr_reg + AW'(pop);
        wr_ptr_reg <= wr_ptr_reg + AW'(push);
      end
      count_reg  <= count_next;
      full_reg   <= count_next == (AW+1)'(DEPTH);
      empty_reg  <= count_next == '0;
      error_reg  <= error_reg | overflow | underflow | (pop & pc_bad);
      result_reg <= pop ? grade : RES_NONE;
      flush_reg  <= mispredict;
      if (mispredict) redirect_reg <= fix_pc;
    end
  end

  assign bus.pred_result = result_reg;
  assign bus.flush       = flush_reg;
  assign bus.redirect_pc = redirect_reg;
  assign bus.full        = full_reg;
  assign bus.empty       = empty_reg;
  assign bus.error       = error_reg;

`ifdef BRU_STATS_EN
  logic [31:0] branches_reg, misses_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branches_reg <= '0;
      misses_reg   <= '0;
    end else begin
      branches_reg <= branches_reg + 32'(pop);
      misses_reg   <= misses_reg + 32'(mispredict);
    end
  end

  assign bus.stat_branches = branches_reg;
  assign bus.stat_misses   = misses_reg;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: queue-based reference model plus literal spot checks.
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_unit_if bus();

  branch_resolve_unit #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  entry_t      q[$];
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  m_result;
  logic        m_flush;
  logic [31:0] m_redirect;
  logic        m_error;
  logic [31:0] m_branches;
  logic [31:0] m_misses;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_result = 2'b00; m_flush = 1'b0; m_redirect = '0; m_error = 1'b0;
    m_branches = '0; m_misses = '0;
  endtask

  // Predicts the registered outputs produced by the next clock edge.
  task automatic model_step();
    int     held;
    logic   miss;
    logic   right;
    entry_t h;
    entry_t e;
    held = q.size();
    miss = 1'b0;
    m_result = 2'b00;
    m_flush  = 1'b0;
    if (!bus.stall) begin
      if (bus.mem_valid) begin
        if (held == 0) m_error = 1'b1;
        else begin
          h = q.pop_front();
          right = (h.pc == bus.mem_pc) &&
                  (bus.mem_taken ? (h.taken && h.target == bus.mem_target) : !h.taken);
          if (h.pc != bus.mem_pc) m_error = 1'b1;
          m_branches++;
          if (right) m_result = 2'd1;
          else begin
            m_result   = bus.mem_taken ? 2'd2 : 2'd3;
            miss       = 1'b1;
            m_misses++;
            m_flush    = 1'b1;
            m_redirect = bus.mem_taken ? bus.mem_target : bus.mem_pc + 32'd4;
            q.delete();
          end
        end
      end
      if (bus.dec_valid && !miss) begin
        if (held == DEPTH) m_error = 1'b1;
        else begin
          e.pc = bus.dec_pc; e.taken = bus.dec_pred_taken; e.target = bus.dec_target;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic compare_all();
    check("pred_result", 32'(bus.pred_result), 32'(m_result));
    check("flush", 32'(bus.flush), 32'(m_flush));
    check("redirect_pc", bus.redirect_pc, m_redirect);
    check("full", 32'(bus.full), 32'(q.size() == DEPTH));
    check("empty", 32'(bus.empty), 32'(q.size() == 0));
    check("error", 32'(bus.error), 32'(m_error));
`ifdef BRU_STATS_EN
    check("stat_branches", bus.stat_branches, m_branches);
    check("stat_misses", bus.stat_misses, m_misses);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic dv, input logic [31:0] dpc, input logic dtk, input logic [31:0] dtg,
                       input logic mv, input logic [31:0] mpc, input logic mtk, input logic [31:0] mtg);
    bus.dec_valid = dv; bus.dec_pc = dpc; bus.dec_pred_taken = dtk; bus.dec_target = dtg;
    bus.mem_valid = mv; bus.mem_pc = mpc; bus.mem_taken = mtk; bus.mem_target = mtg;
  endtask

  task automatic do_reset();
    bus.stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    do_reset();

    // Correct taken prediction
    drive(1, 32'h100, 1, 32'h140, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 32'h100, 1, 32'h140); tick();
    check("t1_result", 32'(bus.pred_result), 32'h1);
    check("t1_flush", 32'(bus.flush), 32'h0);
    check("t1_empty", 32'(bus.empty), 32'h1);

    // Predicted not-taken, actually taken
    drive(1, 32'h200, 0, 32'h0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 32'h200, 1, 32'h280); tick();
    check("t2_result", 32'(bus.pred_result), 32'h2);
    check("t2_flush", 32'(bus.flush), 32'h1);
    check("t2_redirect", bus.redirect_pc, 32'h280);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    check("t2_flush_drop", 32'(bus.flush), 32'h0);
    check("t2_redirect_hold", bus.redirect_pc, 32'h280);

    // Predicted taken, actually not taken, younger entries and same-cycle push squashed
    drive(1, 32'h300, 1, 32'h360, 0, 0, 0, 0); tick();
    drive(1, 32'h304, 0, 32'h0, 0, 0, 0, 0); tick();
    drive(1, 32'h308, 0, 32'h0, 0, 0, 0, 0); tick();
    drive(1, 32'h30c, 0, 32'h0, 1, 32'h300, 0, 32'h0); tick();
    check("t3_result", 32'(bus.pred_result), 32'h3);
    check("t3_redirect", bus.redirect_pc, 32'h304);
    check("t3_empty", 32'(bus.empty), 32'h1);

    // Overflow then drain
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h500 + 32'(4 * i), 1, 32'h600, 0, 0, 0, 0); tick();
    end
    check("t4_full", 32'(bus.full), 32'h1);
    check("t4_error_before", 32'(bus.error), 32'h0);
    drive(1, 32'h510, 1, 32'h600, 0, 0, 0, 0); tick();
    check("t4_error", 32'(bus.error), 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, 0, 1, 32'h500 + 32'(4 * i), 1, 32'h600); tick();
      check("t4_pop", 32'(bus.pred_result), 32'h1);
    end
    check("t4_empty", 32'(bus.empty), 32'h1);
    check("t4_error_sticky", 32'(bus.error), 32'h1);

    // Simultaneous push/pop across pointer wrap, then stall
    do_reset();
    drive(1, 32'h10, 1, 32'h20, 0, 0, 0, 0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h400 + 32'(4 * i), 1, 32'h800, 1, q[0].pc, 1, q[0].target); tick();
      check("t5_pop", 32'(bus.pred_result), 32'h1);
    end
    check("t5_not_empty", 32'(bus.empty), 32'h0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h999, 0, 0, 1, q[0].pc, 1, q[0].target); tick();
      check("t5_stall", 32'(bus.pred_result), 32'h0);
    end
    bus.stall = 1'b0;
    drive(0, 0, 0, 0, 1, 32'h414, 1, 32'h800); tick();
    check("t5_order", 32'(bus.pred_result), 32'h1);

    // Pop on empty, then reset in the middle of a flush
    do_reset();
    drive(0, 0, 0, 0, 1, 32'h123, 0, 0); tick();
    check("t6_underflow_err", 32'(bus.error), 32'h1);
    check("t6_underflow_res", 32'(bus.pred_result), 32'h0);
    drive(1, 32'h900, 1, 32'h940, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 32'h900, 0, 0); tick();
    check("t6_flush", 32'(bus.flush), 32'h1);
    rst = 1'b1;
    #1;
    check("t6_rst_flush", 32'(bus.flush), 32'h0);
    check("t6_rst_redirect", bus.redirect_pc, 32'h0);
    check("t6_rst_empty", 32'(bus.empty), 32'h1);
    check("t6_rst_error", 32'(bus.error), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // Five pops, two of them misses
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'ha00 + 32'(8 * i), 1, 32'hb00, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 1, 32'ha00 + 32'(8 * i), 1, (i < 2) ? 32'hc00 : 32'hb00); tick();
    end
`ifdef BRU_STATS_EN
    check("stat_branches_5", bus.stat_branches, 32'd5);
    check("stat_misses_2", bus.stat_misses, 32'd2);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic        use_head;
      logic [31:0] mpc;
      logic [31:0] mtg;
      if (n % 700 == 0) do_reset();
      use_head = (q.size() > 0) && ($urandom_range(0, 9) != 0);
      mpc = use_head ? q[0].pc : {$urandom_range(0, 255), 2'b00};
      mtg = (use_head && $urandom_range(0, 3) != 0) ? q[0].target : {$urandom_range(0, 255), 2'b00};
      bus.stall = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 1) == 1, {$urandom_range(0, 1023), 2'b00}, $urandom_range(0, 1) == 1,
            {$urandom_range(0, 255), 2'b00},
            $urandom_range(0, 9) < 4, mpc, $urandom_range(0, 1) == 1, mtg);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
